vx_scan_pipe: RTL and testbench

//  Pipelined N-lane parallel-prefix scan (Kogge-Stone) with XOR/AND/OR operator, direction and

---
 rtl/vx_scan_pipe.sv | 106 ++++++++++
 tb/tb_vx_scan_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_scan_pipe.sv
// vx_scan_pipe: pipelined Kogge-Stone prefix scan (XOR/AND/OR) with valid/ready handshake and tag.
// Define VX_SCAN_PERF_EN to add the perf_beats/perf_stalls counter ports.
module vx_scan_pipe #(
  parameter int N = 8,
  parameter int OP = 0,
  parameter int REVERSE = 0,
  parameter int PIPE_LEVELS = 1,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [N-1:0]     data_in,
  input  logic             excl_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [N-1:0]     data_out,
  output logic [TAG_W-1:0] tag_out
`ifdef VX_SCAN_PERF_EN
  ,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stalls
`endif
);
  localparam int LOGN = $clog2(N);
  localparam int S = (LOGN == 0) ? 1 : (LOGN + PIPE_LEVELS - 1) / PIPE_LEVELS;
  localparam logic ID = (OP == 1);
  localparam logic [N-1:0] ID1 = N'(ID);
  if (OP < 0 || OP > 2 || N < 1 || PIPE_LEVELS < 1) begin : g_bad_param
    $error("vx_scan_pipe: illegal parameter value");
  end
  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction
  // One tree level: combine each lane with the lane d positions earlier, identity-filled.
  function automatic logic [N-1:0] lvl(input logic [N-1:0] x, input int d);
    logic [N-1:0] s;
    s = (x << d) | (ID ? ~({N{1'b1}} << d) : '0);
    return (OP == 0) ? (x ^ s) : (OP == 1) ? (x & s) : (x | s);
  endfunction
  logic [N-1:0]     xin, y, ys;
  logic [N-1:0]     nx [S];
  logic [N-1:0]     d_q [S];
  logic [TAG_W-1:0] t_q [S];
  logic [S-1:0]     v, ld, e_q;
  logic             acc;
  // The scan runs in scan order; REVERSE just mirrors the lanes at entry and exit.
  always_comb begin
    xin = (REVERSE != 0) ? rev(data_in) : data_in;
    for (int k = 0; k < S; k++) begin
      nx[k] = (k == 0) ? xin : d_q[(k == 0) ? 0 : k - 1];
      for (int l = k * PIPE_LEVELS; l < (k + 1) * PIPE_LEVELS && l < LOGN; l++)
        nx[k] = lvl(nx[k], 1 << l);
    end
  end
  // A stage may load if any stage from it to the output holds a bubble, or the consumer takes.
  always_comb begin
    ld = '0;
    acc = ready_out;
    for (int k = S - 1; k >= 0; k--) begin
      acc = acc | ~v[k];
      ld[k] = acc;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      e_q <= '0;
      for (int k = 0; k < S; k++) begin
        d_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else
      for (int k = 0; k < S; k++)
        if (ld[k]) begin
          v[k] <= (k == 0) ? valid_in : v[(k == 0) ? 0 : k - 1];
          if ((k == 0) ? valid_in : v[(k == 0) ? 0 : k - 1]) begin
            d_q[k] <= nx[k];
            t_q[k] <= (k == 0) ? tag_in : t_q[(k == 0) ? 0 : k - 1];
            e_q[k] <= (k == 0) ? excl_in : e_q[(k == 0) ? 0 : k - 1];
          end
        end
  // Exclusive result is the inclusive result shifted one lane in scan order.
  always_comb begin
    y = d_q[S-1];
    ys = e_q[S-1] ? ((y << 1) | ID1) : y;
  end
  assign data_out  = (REVERSE != 0) ? rev(ys) : ys;
  assign tag_out   = t_q[S-1];
  assign valid_out = v[S-1];
  assign ready_in  = ld[0];
`ifdef VX_SCAN_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      perf_beats <= '0;
      perf_stalls <= '0;
    end else begin
      if (valid_out & ready_out) perf_beats <= perf_beats + 32'd1;
      if (valid_out & ~ready_out) perf_stalls <= perf_stalls + 32'd1;
    end
`endif
endmodule

// File: tb/tb_vx_scan_pipe.sv
// tb_vx_scan_pipe: directed and random checks of vx_scan_pipe with a queue scoreboard.
module tb_vx_scan_pipe;
  logic clk = 0;
  always #5 clk = ~clk;
  logic       reset_n, valid_in, ready_in, excl_in, valid_out, ready_out;
  logic [7:0] data_in, data_out;
  logic [3:0] tag_in, tag_out;
  logic       a_v, a_e, a_t, a_ro;
  logic [7:0] a_d;
  logic [2:0] a_ri, a_vo;
  logic [7:0] a_do [3];
  logic       a_to [3];
`ifdef VX_SCAN_PERF_EN
  logic [31:0] perf_beats, perf_stalls;
  logic [31:0] a_pb [3];
  logic [31:0] a_ps [3];
`endif
  vx_scan_pipe #(.N(8), .OP(0), .REVERSE(0), .PIPE_LEVELS(1), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .excl_in(excl_in), .tag_in(tag_in), .valid_out(valid_out),
    .ready_out(ready_out), .data_out(data_out), .tag_out(tag_out)
`ifdef VX_SCAN_PERF_EN
    , .perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
  );
  // Side instances: 0 = OR lo->hi, 1 = AND lo->hi, 2 = AND hi->lo, two levels per stage.
  for (genvar g = 0; g < 3; g++) begin : g_aux
    vx_scan_pipe #(.N(8), .OP(g == 0 ? 2 : 1), .REVERSE(g == 2 ? 1 : 0), .PIPE_LEVELS(2), .TAG_W(1)) u (
      .clk(clk), .reset_n(reset_n), .valid_in(a_v), .ready_in(a_ri[g]),
      .data_in(a_d), .excl_in(a_e), .tag_in(a_t), .valid_out(a_vo[g]),
      .ready_out(a_ro), .data_out(a_do[g]), .tag_out(a_to[g])
`ifdef VX_SCAN_PERF_EN
      , .perf_beats(a_pb[g]), .perf_stalls(a_ps[g])
`endif
    );
  end
  int         checks = 0, failures = 0, ret_n = 0, stl_n = 0, n;
  logic [7:0] qd [$];
  logic [3:0] qt [$];
  logic [7:0] hold_d, rd;
  logic [3:0] hold_t;
  logic       re;
  bit         hold_v, vo_s, acc_s, ri_s;
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [7:0] d, input logic ex, input int op, input bit rv);
    logic [7:0] r;
    logic a;
    bit cov;
    for (int i = 0; i < 8; i++) begin
      a = (op == 1);
      for (int j = 0; j < 8; j++) begin
        cov = rv ? (ex ? j > i : j >= i) : (ex ? j < i : j <= i);
        if (cov) a = (op == 0) ? (a ^ d[j]) : (op == 1) ? (a & d[j]) : (a | d[j]);
      end
      r[i] = a;
    end
    return r;
  endfunction
  // One cycle: observe handshakes at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    vo_s = valid_out;
    ri_s = ready_in;
    acc_s = valid_in && ready_in;
    if (acc_s) begin
      qd.push_back(model(data_in, excl_in, 0, 0));
      qt.push_back(tag_in);
    end
    if (hold_v) begin
      chk("stall_valid", valid_out, 1);
      chk("stall_data", data_out, hold_d);
      chk("stall_tag", tag_out, hold_t);
    end
    hold_v = valid_out && !ready_out;
    hold_d = data_out;
    hold_t = tag_out;
    if (hold_v) stl_n++;
    if (valid_out && ready_out) begin
      ret_n++;
      chk("retire_expected", qd.size() != 0, 1);
      if (qd.size() != 0) begin
        chk("retire_data", data_out, qd.pop_front());
        chk("retire_tag", tag_out, qt.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic aux_beat(input logic [7:0] d, input logic e, input logic [7:0] x_or,
                          input logic [7:0] x_and, input logic [7:0] x_andr);
    chk("aux_ready_in", a_ri, 3'b111);
    a_v = 1;
    a_d = d;
    a_e = e;
    a_t = d[0] ^ e;
    tick();
    a_v = 0;
    n = 0;
    while (!a_vo[0] && n < 8) begin
      tick();
      n++;
    end
    chk("aux_latency", n, 1);
    chk("aux_valid", a_vo, 3'b111);
    chk("aux_or", a_do[0], x_or);
    chk("aux_and", a_do[1], x_and);
    chk("aux_and_rev", a_do[2], x_andr);
    chk("aux_tag", {a_to[2], a_to[1], a_to[0]}, {3{a_t}});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 0; valid_in = 0; data_in = 0; excl_in = 0; tag_in = 0; ready_out = 0;
    a_v = 0; a_d = 0; a_e = 0; a_t = 0; a_ro = 1; hold_v = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_tag_out", tag_out, 0);
    chk("rst_aux_valid", a_vo, 0);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("rst_ready_in", ready_in, 1);
    aux_beat(8'h10, 0, 8'hF0, 8'h00, 8'h00);
    aux_beat(8'h10, 1, 8'hE0, 8'h01, 8'h80);
    aux_beat(8'h0F, 0, 8'hFF, 8'h0F, 8'h00);
    aux_beat(8'h0F, 1, 8'hFE, 8'h1F, 8'h80);
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      re = 1'($urandom);
      aux_beat(rd, re, model(rd, re, 2, 0), model(rd, re, 1, 0), model(rd, re, 1, 1));
    end
    ready_out = 1;
    data_in = 8'hFF; excl_in = 0; tag_in = 4'h1; valid_in = 1;
    tick();
    chk("lat_accept", acc_s, 1);
    valid_in = 0;
    n = 0;
    while (!valid_out && n < 10) begin
      tick();
      n++;
    end
    chk("lat_t_plus_3", n, 2);
    chk("lat_data", data_out, 8'h55);
    chk("lat_tag", tag_out, 4'h1);
    tick();
    for (int b = 0; b < 10; b++) begin
      data_in = 8'($urandom); excl_in = 1'($urandom); tag_in = 4'($urandom); valid_in = 1;
      n = 0;
      do begin
        ready_out = 1'($urandom);
        tick();
        n++;
      end while (!acc_s && n < 50);
      chk("stream_accept", acc_s, 1);
    end
    valid_in = 0;
    n = 0;
    while (qd.size() != 0 && n < 100) begin
      ready_out = 1'($urandom);
      tick();
      n++;
    end
    chk("stream_drained", qd.size(), 0);
    ready_out = 0;
    tick();
    chk("stream_idle", vo_s, 0);
    valid_in = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'($urandom); excl_in = 1'($urandom); tag_in = 4'(i);
      tick();
      if (!acc_s) break;
      n++;
    end
    chk("fill_accepts", n, 3);
    chk("fill_ready_low", ri_s, 0);
    chk("fill_valid_out", vo_s, 1);
    ready_out = 1;
    tick();
    chk("full_accept_retire", {acc_s, vo_s}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      data_in = 8'($urandom); excl_in = 1'($urandom); tag_in = 4'($urandom);
      tick();
      chk("thru_accept", acc_s, 1);
      chk("thru_retire", vo_s, 1);
    end
    valid_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_rate", vo_s, 1);
    end
    tick();
    chk("drain_empty", vo_s, 0);
    chk("drain_queue", qd.size(), 0);
    ready_out = 0;
    valid_in = 1;
    for (int i = 0; i < 2; i++) begin
      data_in = 8'($urandom); excl_in = 0; tag_in = 4'hA;
      tick();
    end
    valid_in = 0;
    tick();
    chk("flight_valid", valid_out, 1);
`ifdef VX_SCAN_PERF_EN
    chk("perf_beats", perf_beats, ret_n);
    chk("perf_stalls", perf_stalls, stl_n);
`endif
    reset_n = 0;
    #1;
    chk("reset_async_valid", valid_out, 0);
    qd.delete();
    qt.delete();
    hold_v = 0;
    tick();
    tick();
    chk("reset_data", data_out, 0);
    chk("reset_tag", tag_out, 0);
`ifdef VX_SCAN_PERF_EN
    chk("reset_perf_beats", perf_beats, 0);
    chk("reset_perf_stalls", perf_stalls, 0);
`endif
    reset_n = 1;
    ready_out = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_no_beat", vo_s, 0);
    end
    chk("post_reset_ready_in", ready_in, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
